// File: rtl/sig_frame_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sig_frame_loader_if : host word stream into the signature frame loader
// Rev 1.0
// ---------------------------------------------------------------------------
interface sig_frame_loader_if #(
  parameter int WORD_BW = 64
);
  logic               mode_i;
  logic               in_valid;
  logic [WORD_BW-1:0] in_data;
  logic               in_last;
  logic               in_ready;

  modport master (
    output mode_i, in_valid, in_data, in_last,
    input  in_ready
  );

  modport slave (
    input  mode_i, in_valid, in_data, in_last,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/sig_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sig_frame_loader : assembles key + data frame, issues one AES/SHA3 start
// Rev 1.0
// ---------------------------------------------------------------------------
module sig_frame_loader #(
  parameter int SHA_DATA_BW = 256,
  parameter int AES_TXT_BW  = 128,
  parameter int WORD_BW     = 64
) (
  input  wire logic                  clk,
  input  wire logic                  srst_n,
  sig_frame_loader_if.slave          host,
  input  wire logic                  job_done,
  output logic [AES_TXT_BW-1:0]      aes_key_o,
  output logic [AES_TXT_BW-1:0]      aes_msb_i,
  output logic [AES_TXT_BW-1:0]      aes_lsb_i,
  output logic                       mode_o,
  output logic                       start_o,
  output logic                       busy_o,
  output logic                       frame_err_o
);

  localparam int       c_STG_BW    = SHA_DATA_BW - WORD_BW;
  localparam bit [2:0] c_LAST_WORD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_wcnt;
  logic [2:0]            w_wcnt_nxt;
  logic                  w_hs;
  logic                  w_commit;
  logic [AES_TXT_BW-1:0] r_stg_key;
  logic [c_STG_BW-1:0]   r_stg_data;
  logic                  r_stg_mode;

  assign host.in_ready = srst_n & ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign w_hs          = host.in_valid & host.in_ready;
  assign start_o       = (r_state == S_ISSUE);
  assign frame_err_o   = (r_state == S_ERR);
  assign busy_o        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_commit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (host.in_last) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_LOAD;
            w_wcnt_nxt  = 3'd1;
          end
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          if (r_wcnt == c_LAST_WORD) begin
            if (host.in_last) begin
              w_state_nxt = S_ISSUE;
              w_wcnt_nxt  = 3'd0;
              w_commit    = 1'b1;
            end else begin
              w_state_nxt = S_ERR;
            end
          end else if (host.in_last) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wcnt_nxt = 3'(r_wcnt + 3'd1);
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (job_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = 3'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = 3'd0;
      end
    endcase
  end

  // Staging absorbs w0..w4; w5 goes straight into the LSB output on commit.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_stg_key  <= '0;
      r_stg_data <= '0;
      r_stg_mode <= 1'b0;
    end else if (w_hs) begin
      case (r_wcnt)
        3'd0: begin
          r_stg_key[AES_TXT_BW-1 -: WORD_BW] <= host.in_data;
          r_stg_mode                         <= host.mode_i;
        end
        3'd1: r_stg_key[WORD_BW-1:0]                      <= host.in_data;
        3'd2: r_stg_data[c_STG_BW-1 -: WORD_BW]           <= host.in_data;
        3'd3: r_stg_data[c_STG_BW-1-WORD_BW -: WORD_BW]   <= host.in_data;
        3'd4: r_stg_data[WORD_BW-1:0]                     <= host.in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      aes_key_o <= '0;
      aes_msb_i <= '0;
      aes_lsb_i <= '0;
      mode_o    <= 1'b0;
    end else if (w_commit) begin
      aes_key_o <= r_stg_key;
      aes_msb_i <= r_stg_data[c_STG_BW-1 -: AES_TXT_BW];
      aes_lsb_i <= {r_stg_data[WORD_BW-1:0], host.in_data};
      mode_o    <= r_stg_mode;
    end
  end

endmodule
`default_nettype wire
